mem_stage: RTL

- MEM pipeline stage, directly downstream of the EX stage via the EX/MEM register.
- Executes loads and stores against a byte-wide, single-port synchronous RAM.
- Multi-byte accesses are serialised one byte per cycle; the pipeline is stalled until the access completes.
- Non-memory ops pass their EX result through to MEM/WB with one cycle of latency.

---
 rtl/mem_stage_pkg.sv | 50 +++++
 rtl/mem_stage_if.sv | 38 +++
 rtl/mem_load_ext.sv | 21 ++
 rtl/mem_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, ALU op codes and FSM encoding for the MEM stage.
// Helper functions classify memory ops and give the index of their last byte.
package mem_stage_pkg;

    localparam int unsigned AluLen     = 5;
    localparam int unsigned AddrLen    = 32;
    localparam int unsigned RegLen     = 32;
    localparam int unsigned RegAddrLen = 5;
    localparam int unsigned ByteLen    = 8;

    localparam logic [AluLen-1:0] OpNop = 5'd0;
    localparam logic [AluLen-1:0] OpAdd = 5'd1;
    localparam logic [AluLen-1:0] OpSub = 5'd2;
    localparam logic [AluLen-1:0] OpAnd = 5'd3;
    localparam logic [AluLen-1:0] OpOr  = 5'd4;
    localparam logic [AluLen-1:0] OpLb  = 5'd16;
    localparam logic [AluLen-1:0] OpLh  = 5'd17;
    localparam logic [AluLen-1:0] OpLw  = 5'd18;
    localparam logic [AluLen-1:0] OpLbu = 5'd19;
    localparam logic [AluLen-1:0] OpLhu = 5'd20;
    localparam logic [AluLen-1:0] OpSb  = 5'd21;
    localparam logic [AluLen-1:0] OpSh  = 5'd22;
    localparam logic [AluLen-1:0] OpSw  = 5'd23;

    typedef enum logic [2:0] {
        MemIdle  = 3'd0,
        MemLoad  = 3'd1,
        MemLast  = 3'd2,
        MemStore = 3'd3,
        MemDone  = 3'd4
    } mem_state_e;

    function automatic logic is_load(input logic [AluLen-1:0] op);
        return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
    endfunction

    function automatic logic is_store(input logic [AluLen-1:0] op);
        return op inside {OpSb, OpSh, OpSw};
    endfunction

    // Access size minus one, so it fits the 2-bit byte counter.
    function automatic logic [1:0] mem_last_idx(input logic [AluLen-1:0] op);
        case (op)
            OpLh, OpLhu, OpSh: return 2'd1;
            OpLw, OpSw:        return 2'd3;
            default:           return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, RAM port and MEM/WB outputs of the MEM stage.
// master is the stage itself; slave is the surrounding pipeline and RAM.
interface mem_stage_if
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 32
) ();

    logic                  in_valid;
    logic [AluLen-1:0]     alu_op;
    logic [AddrLen-1:0]    mem_addr;
    logic [RegLen-1:0]     mem_wdata;
    logic [RegLen-1:0]     rd_data;
    logic [RegAddrLen-1:0] rd_addr;
    logic                  rd_enable;

    logic [MEM_ADDR_W-1:0] ram_a;
    logic                  ram_wr;
    logic [ByteLen-1:0]    ram_dout;
    logic [ByteLen-1:0]    ram_din;

    logic                  stall_req;
    logic                  wb_valid;
    logic [RegLen-1:0]     wb_data;
    logic [RegAddrLen-1:0] wb_addr;
    logic                  wb_enable;

    modport master (
        input  in_valid, alu_op, mem_addr, mem_wdata, rd_data, rd_addr, rd_enable, ram_din,
        output ram_a, ram_wr, ram_dout, stall_req, wb_valid, wb_data, wb_addr, wb_enable
    );

    modport slave (
        output in_valid, alu_op, mem_addr, mem_wdata, rd_data, rd_addr, rd_enable, ram_din,
        input  ram_a, ram_wr, ram_dout, stall_req, wb_valid, wb_data, wb_addr, wb_enable
    );

endinterface

// File: rtl/mem_load_ext.sv
// Sign- or zero-extends an assembled little-endian load word according to the load op.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [RegLen-1:0] word_i,
    input  logic [AluLen-1:0] alu_op_i,
    output logic [RegLen-1:0] result_o
);

    always_comb begin
        result_o = word_i;
        case (alu_op_i)
            OpLb:    result_o = {{24{word_i[7]}}, word_i[7:0]};
            OpLbu:   result_o = {24'h0, word_i[7:0]};
            OpLh:    result_o = {{16{word_i[15]}}, word_i[15:0]};
            OpLhu:   result_o = {16'h0, word_i[15:0]};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: serialises loads/stores one byte per cycle over a byte-wide
// synchronous RAM, stalling upstream; non-memory ops pass through in one cycle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_ADDR_W = 32
) (
    input logic         clk,
    input logic         rst,
    mem_stage_if.master bus
);

    mem_state_e            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d, cnt_m1;
    logic [AluLen-1:0]     op_q, op_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [RegLen-1:0]     wdata_q, wdata_d;
    logic [RegLen-1:0]     data_q, data_d;
    logic [RegAddrLen-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [RegLen-1:0]     wb_data_q, wb_data_d;
    logic [RegAddrLen-1:0] wb_addr_q, wb_addr_d;
    logic                  wb_en_q, wb_en_d;

    logic                  stall, ram_wr, is_last;
    logic [ByteLen-1:0]    ram_dout;
    logic [RegLen-1:0]     last_word, ext_word;

    assign cnt_m1  = cnt_q - 2'd1;
    assign is_last = (cnt_q == mem_last_idx(op_q));

    // Word as it will look once the byte arriving this cycle is merged in.
    always_comb begin
        last_word = data_q;
        last_word[{cnt_q, 3'b000} +: ByteLen] = bus.ram_din;
    end

    mem_load_ext u_load_ext (
        .word_i   (last_word),
        .alu_op_i (op_q),
        .result_o (ext_word)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = rd_en_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_addr_d  = wb_addr_q;
        wb_en_d    = wb_en_q;
        stall      = 1'b0;
        ram_wr     = 1'b0;
        ram_dout   = '0;

        case (state_q)
            MemIdle: begin
                if (bus.in_valid) begin
                    if (is_load(bus.alu_op) || is_store(bus.alu_op)) begin
                        stall     = 1'b1;
                        op_d      = bus.alu_op;
                        addr_d    = bus.mem_addr[MEM_ADDR_W-1:0];
                        wdata_d   = bus.mem_wdata;
                        rd_addr_d = bus.rd_addr;
                        rd_en_d   = bus.rd_enable;
                        cnt_d     = 2'd0;
                        state_d   = is_load(bus.alu_op) ? MemLoad : MemStore;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = bus.rd_data;
                        wb_addr_d  = bus.rd_addr;
                        wb_en_d    = bus.rd_enable;
                    end
                end
            end
            MemLoad: begin
                stall = 1'b1;
                // RAM returns the previous cycle's address, so capture lags by one byte.
                if (cnt_q != 2'd0) begin
                    data_d[{cnt_m1, 3'b000} +: ByteLen] = bus.ram_din;
                end
                if (is_last) begin
                    state_d = MemLast;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            MemLast: begin
                stall      = 1'b1;
                data_d     = last_word;
                state_d    = MemDone;
                wb_valid_d = 1'b1;
                wb_data_d  = ext_word;
                wb_addr_d  = rd_addr_q;
                wb_en_d    = rd_en_q;
            end
            MemStore: begin
                stall    = 1'b1;
                ram_wr   = 1'b1;
                ram_dout = wdata_q[{cnt_q, 3'b000} +: ByteLen];
                if (is_last) begin
                    state_d    = MemDone;
                    wb_valid_d = 1'b1;
                    wb_data_d  = '0;
                    wb_addr_d  = rd_addr_q;
                    wb_en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            MemDone: begin
                state_d = MemIdle;
            end
            default: begin
                state_d = MemIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= MemIdle;
            cnt_q      <= 2'd0;
            op_q       <= OpNop;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_addr_q  <= '0;
            wb_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_addr_q  <= wb_addr_d;
            wb_en_q    <= wb_en_d;
        end
    end

    assign bus.ram_a     = addr_q + MEM_ADDR_W'(cnt_q);
    assign bus.ram_wr    = ram_wr;
    assign bus.ram_dout  = ram_dout;
    assign bus.stall_req = stall & rst;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_enable = wb_en_q;

endmodule
